// File: rtl/popcount_scheduler_if.sv
// Handshake bundle for popcount_scheduler: input word channel and result channel.
// The block uses the slave modport; the producer/consumer side uses master.
interface popcount_scheduler_if #(
  parameter int N_BYTES = 4
);
  localparam int OUT_W = $clog2(8 * N_BYTES + 1);

  logic                   I_valid;
  logic                   I_ready;
  logic [8*N_BYTES-1:0]   I_data;
  logic                   O_valid;
  logic                   O_ready;
  logic [OUT_W-1:0]       O_count;

  modport master (
    output I_valid, I_data, O_ready,
    input  I_ready, O_valid, O_count
  );

  modport slave (
    input  I_valid, I_data, O_ready,
    output I_ready, O_valid, O_count
  );
endinterface

// File: rtl/popcount_scheduler.sv
// Serial popcount: one 8-bit slice per cycle through a shared counter, IDLE/COUNT/DONE.
// Define POPCOUNT_SCHEDULER_ZERO_SKIP_EN to finish early once all remaining slices are zero.
module popcount_scheduler #(
  parameter int N_BYTES = 4
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESET,
  popcount_scheduler_if.slave  bus,
  output logic                 busy
);

  localparam int W     = 8 * N_BYTES;
  localparam int OUT_W = $clog2(8 * N_BYTES + 1);
  localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     shift_q;
  logic [OUT_W-1:0] acc_q;
  logic [IDX_W-1:0] idx_q;
  logic [3:0]       slice_pc;
  logic             last_slice;

  function automatic logic [3:0] popcount8(input logic [7:0] b);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, b[i]};
    return n;
  endfunction

  assign slice_pc = popcount8(shift_q[7:0]);

`ifdef POPCOUNT_SCHEDULER_ZERO_SKIP_EN
  // Stop as soon as nothing left in the shift register can add to the count.
  assign last_slice = (idx_q == IDX_W'(N_BYTES - 1)) || ((shift_q >> 8) == '0);
`else
  assign last_slice = (idx_q == IDX_W'(N_BYTES - 1));
`endif

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.I_valid) state_d = COUNT;
      COUNT:   if (last_slice)  state_d = DONE;
      DONE:    if (bus.O_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: the shift register is reset as well, so a word in flight is wiped, not just ignored.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q <= IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.I_valid) begin
            shift_q <= bus.I_data;
            acc_q   <= '0;
            idx_q   <= '0;
          end
        end
        COUNT: begin
          acc_q   <= acc_q + OUT_W'(slice_pc);
          shift_q <= shift_q >> 8;
          idx_q   <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.I_ready = (state_q == IDLE) && !ASYNCRESET;
  assign bus.O_valid = (state_q == DONE);
  assign bus.O_count = (state_q == DONE) ? acc_q : '0;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_popcount_scheduler.sv
// Self-checking bench for popcount_scheduler (N_BYTES=4): directed cases plus random traffic
// compared every cycle against a transaction-level model (accepted word, latency, result).
module tb_popcount_scheduler;

  logic clk;
  logic rst;
  logic busy;

  popcount_scheduler_if #(.N_BYTES(4)) bus ();

  popcount_scheduler #(.N_BYTES(4)) dut (
    .CLK        (clk),
    .ASYNCRESET (rst),
    .bus        (bus),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected cycles from acceptance to result, straight from the latency rules.
  function automatic int exp_latency(input logic [31:0] w);
    int l;
`ifdef POPCOUNT_SCHEDULER_ZERO_SKIP_EN
    l = 1;
    for (int b = 0; b < 4; b++) if (w[8*b +: 8] != 8'h00) l = b + 1;
`else
    l = 4;
`endif
    return l;
  endfunction

  // Transaction-level model: idle / counting down a latency / holding a result.
  bit          m_busy    = 1'b0;
  bit          m_done    = 1'b0;
  int          m_left    = 0;
  logic [31:0] m_word    = '0;
  int          m_results = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
    end else if (!m_busy) begin
      if (bus.I_valid) begin
        m_word <= bus.I_data;
        m_left <= exp_latency(bus.I_data);
        m_busy <= 1'b1;
      end
    end else if (!m_done) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_done <= 1'b1;
    end else if (bus.O_ready) begin
      m_busy    <= 1'b0;
      m_done    <= 1'b0;
      m_results <= m_results + 1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("o_valid", bus.O_valid, m_done);
    check("o_count", bus.O_count, m_done ? $countones(m_word) : 0);
    check("i_ready", bus.I_ready, (!m_busy && !rst));
    check("busy",    busy,        m_busy);
  end

  // Result observer and small event counters used by directed cases.
  logic [5:0] res_q[$];
  int n_res     = 0;
  int busy_cnt  = 0;
  int valid_cnt = 0;

  always @(negedge clk) begin
    if (bus.O_valid && bus.O_ready) begin
      res_q.push_back(bus.O_count);
      n_res++;
    end
    if (busy)        busy_cnt++;
    if (bus.O_valid) valid_cnt++;
  end

  // Called at posedge+1; returns at posedge+1 after the acceptance edge.
  task automatic send_word(input logic [31:0] w, output int acc);
    bit hs;
    hs = 1'b0;
    bus.I_data  = w;
    bus.I_valid = 1'b1;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk);
      hs = bus.I_ready;
      @(posedge clk);
      #1;
    end
    if (!hs) check("send_timeout", 0, 1);
    acc = cyc;
    bus.I_valid = 1'b0;
  endtask

  // Returns at the first negedge showing O_valid, with the cycle number.
  task automatic wait_result(output logic [5:0] c, output int r);
    bit found;
    found = 1'b0;
    c = '0;
    r = cyc;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (bus.O_valid) begin
        found = 1'b1;
        c = bus.O_count;
        r = cyc;
      end
    end
    if (!found) check("result_timeout", 0, 1);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    for (int b = 0; b < 4; b++) if ($urandom_range(0, 2) == 0) w[8*b +: 8] = 8'h00;
    return w;
  endfunction

  logic [31:0] skip_words [3] = '{32'h0000_00FF, 32'h0000_0000, 32'hFF00_0000};
  int          skip_cnt   [3] = '{8, 0, 8};
`ifdef POPCOUNT_SCHEDULER_ZERO_SKIP_EN
  int          skip_lat   [3] = '{1, 1, 4};
`else
  int          skip_lat   [3] = '{4, 4, 4};
`endif

  initial begin
    int a, a2, r, rr;
    logic [5:0] c;

    rst         = 1'b1;
    bus.I_valid = 1'b0;
    bus.I_data  = '0;
    bus.O_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_i_ready", bus.I_ready, 0);
    check("rst_o_valid", bus.O_valid, 0);
    check("rst_o_count", bus.O_count, 0);
    check("rst_busy",    busy,        0);
    rst = 1'b0;
    @(negedge clk);
    check("release_i_ready", bus.I_ready, 1);

    // All ones: fixed latency 4, count 32, busy for 5 cycles
    @(posedge clk); #1;
    bus.O_ready = 1'b1;
    busy_cnt = 0;
    send_word(32'hFFFF_FFFF, a);
    wait_result(c, r);
    check("ones_latency", r - a, 4);
    check("ones_count",   c,     32);
    repeat (3) @(posedge clk);
    #1;
    check("ones_busy_cycles", busy_cnt, 5);

    // Back-pressure: result held, next word waits for O_ready
    bus.O_ready = 1'b0;
    send_word(32'h8000_0001, a);
    wait_result(c, r);
    check("hold_count", c, 2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.I_valid = 1'b1;
      bus.I_data  = 32'h0000_00F0;
      @(negedge clk);
      check("hold_o_valid", bus.O_valid, 1);
      check("hold_o_count", bus.O_count, 2);
      check("hold_i_ready", bus.I_ready, 0);
    end
    @(posedge clk); #1;
    bus.O_ready = 1'b1;
    rr = cyc;
    send_word(32'h0000_00F0, a);
    check("hold_accept_delay", a - rr, 2);
    wait_result(c, r);
    check("hold_next_count", c, 4);

    // Constant I_valid/O_ready: acceptances N_BYTES+2 apart
    @(posedge clk); #1;
    @(posedge clk); #1;
    res_q.delete();
    send_word(32'h0F0F_0F0F, a);
    send_word(32'h0000_0003, a2);
    check("b2b_spacing", a2 - a, 6);
    repeat (10) @(posedge clk);
    #1;
    check("b2b_n_results", res_q.size(), 2);
    if (res_q.size() == 2) begin
      check("b2b_first",  res_q[0], 16);
      check("b2b_second", res_q[1], 2);
    end

    // Async reset in the middle of slice 2
    valid_cnt = 0;
    send_word(32'hFFFF_FFFF, a);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_o_valid", bus.O_valid, 0);
    check("mid_rst_o_count", bus.O_count, 0);
    check("mid_rst_busy",    busy,        0);
    check("mid_rst_i_ready", bus.I_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("mid_rst_no_valid", valid_cnt, 0);
    send_word(32'h0000_0001, a);
    wait_result(c, r);
    check("after_rst_count", c, 1);

    // Latency with and without zero skipping
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      send_word(skip_words[k], a);
      wait_result(c, r);
      check($sformatf("skip_latency_%0d", k), r - a, skip_lat[k]);
      check($sformatf("skip_count_%0d", k),   c,     skip_cnt[k]);
    end

    // Random traffic; every cycle is compared by the model process
    @(posedge clk); #1;
    for (int i = 0; i < 40000; i++) begin
      @(posedge clk); #1;
      bus.I_valid = ($urandom_range(0, 3) != 0);
      bus.O_ready = ($urandom_range(0, 2) != 0);
      bus.I_data  = rand_word();
    end
    bus.I_valid = 1'b0;
    bus.O_ready = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("drain_busy",    busy,  0);
    check("result_totals", n_res, m_results);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
